// File: rtl/tpu_pkg.sv
// Shared tiny-TPU definitions: instruction width, opcodes, END word and loader FSM states.
package tpu_pkg;

  localparam int unsigned INSTR_W = 16;

  typedef enum logic [2:0] {
    OP_NOP_END     = 3'b000,
    OP_LOAD_ADDR   = 3'b001,
    OP_LOAD_WEIGHT = 3'b010,
    OP_LOAD_INPUT  = 3'b011,
    OP_COMPUTE     = 3'b100,
    OP_STORE       = 3'b101
  } opcode_t;

  // A NOP word with zero operand doubles as the program terminator.
  localparam logic [INSTR_W-1:0] END_WORD = '0;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD_HI = 3'd1,
    S_LOAD_LO = 3'd2,
    S_WRITE   = 3'd3,
    S_DONE    = 3'd4
  } loader_state_t;

endpackage

// File: rtl/instr_mem.sv
// Instruction storage: one write port, one registered read port, async clear.
module instr_mem #(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned INSTR_W = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [$clog2(DEPTH)-1:0]   wr_addr,
  input  logic [INSTR_W-1:0]         wr_data,
  input  logic [$clog2(DEPTH)-1:0]   rd_addr,
  output logic [INSTR_W-1:0]         rd_data
);

  logic [INSTR_W-1:0] mem [DEPTH];

  // Read samples the pre-write contents, so a same-address read returns the old word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd_data <= '0;
    end else begin
      if (wr_en) mem[wr_addr] <= wr_data;
      rd_data <= (32'(rd_addr) < DEPTH) ? mem[rd_addr] : '0;
    end
  end

endmodule

// File: rtl/instr_loader.sv
// Byte-serial program loader: packs host bytes into instruction words for the sequencer.
module instr_loader #(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned INSTR_W = 16,
  parameter int unsigned BYTE_W  = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       load_start,
  input  logic [BYTE_W-1:0]          byte_in,
  input  logic                       byte_valid,
  output logic                       byte_ready,
  input  logic [$clog2(DEPTH)-1:0]   rd_addr,
  output logic [INSTR_W-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]     instr_count,
  output logic                       program_ready,
  output logic                       overflow
);

  import tpu_pkg::*;

  localparam int unsigned AW = $clog2(DEPTH);

  loader_state_t      state;
  logic [BYTE_W-1:0]  hi_q;
  logic [BYTE_W-1:0]  lo_q;
  logic [INSTR_W-1:0] word;
  logic               wr_en;

  assign word  = {hi_q, lo_q};
  assign wr_en = (state == S_WRITE) && !load_start;

  // load_start pre-empts the handshake so a byte offered alongside it is not taken.
  assign byte_ready = ((state == S_LOAD_HI) || (state == S_LOAD_LO)) && !load_start;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= S_IDLE;
      hi_q          <= '0;
      lo_q          <= '0;
      instr_count   <= '0;
      program_ready <= 1'b0;
      overflow      <= 1'b0;
    end else if (load_start) begin
      state         <= S_LOAD_HI;
      instr_count   <= '0;
      program_ready <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      case (state)
        S_LOAD_HI: if (byte_valid) begin
          hi_q  <= byte_in;
          state <= S_LOAD_LO;
        end
        S_LOAD_LO: if (byte_valid) begin
          lo_q  <= byte_in;
          state <= S_WRITE;
        end
        S_WRITE: begin
          instr_count <= instr_count + 1'b1;
          if (word == END_WORD) begin
            program_ready <= 1'b1;
            state         <= S_DONE;
          end else if (32'(instr_count) + 32'd1 == DEPTH) begin
            overflow <= 1'b1;
            state    <= S_DONE;
          end else begin
            state <= S_LOAD_HI;
          end
        end
        default: ;
      endcase
    end
  end

  instr_mem #(
    .DEPTH   (DEPTH),
    .INSTR_W (INSTR_W)
  ) u_mem (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_addr (instr_count[AW-1:0]),
    .wr_data (word),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader against a program-level reference model.
module tb_instr_loader;

  localparam int unsigned DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        load_start = 1'b0;
  logic [7:0]  byte_in = '0;
  logic        byte_valid = 1'b0;
  logic        byte_ready;
  logic [2:0]  rd_addr = '0;
  logic [15:0] rd_data;
  logic [3:0]  instr_count;
  logic        program_ready;
  logic        overflow;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  bit vphase = 1'b0;

  logic [15:0] mmem [DEPTH];
  int          m_count = 0;
  bit          m_pr = 1'b0;
  bit          m_ov = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  instr_loader #(
    .DEPTH   (8),
    .INSTR_W (16),
    .BYTE_W  (8)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .load_start    (load_start),
    .byte_in       (byte_in),
    .byte_valid    (byte_valid),
    .byte_ready    (byte_ready),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .instr_count   (instr_count),
    .program_ready (program_ready),
    .overflow      (overflow)
  );

  function automatic void model_clear_mem();
    for (int i = 0; i < int'(DEPTH); i++) mmem[i] = '0;
    m_count = 0;
    m_pr = 1'b0;
    m_ov = 1'b0;
  endfunction

  // Program-level model: words fill memory until END or until memory is full.
  function automatic int model_load(input logic [15:0] w[$]);
    m_count = 0;
    m_pr = 1'b0;
    m_ov = 1'b0;
    foreach (w[i]) begin
      mmem[m_count] = w[i];
      m_count++;
      if (w[i] == 16'h0000) begin
        m_pr = 1'b1;
        return m_count;
      end
      if (m_count == int'(DEPTH)) begin
        m_ov = 1'b1;
        return m_count;
      end
    end
    return m_count;
  endfunction

  task automatic pulse_start();
    @(negedge clk);
    load_start = 1'b1;
    byte_valid = 1'b0;
    @(posedge clk);
    #1 load_start = 1'b0;
  endtask

  // mode 0: valid always high, 1: toggled every cycle, 2: random
  task automatic send_byte(input logic [7:0] b, input int mode);
    bit done;
    done = 1'b0;
    for (int k = 0; k < 60 && !done; k++) begin
      @(negedge clk);
      byte_in = b;
      case (mode)
        0: byte_valid = 1'b1;
        1: begin vphase = ~vphase; byte_valid = vphase; end
        default: byte_valid = 1'($urandom_range(0, 1));
      endcase
      #1;
      if (byte_valid && byte_ready) begin
        @(posedge clk);
        done = 1'b1;
      end
    end
    vectors++;
    if (!done) begin
      miscompares++;
      $display("FAIL byte_accept: byte %h not accepted within 60 cycles (byte_ready=%b), required accepted", b, byte_ready);
    end
  endtask

  task automatic send_word(input logic [15:0] w, input int mode);
    send_byte(w[15:8], mode);
    send_byte(w[7:0], mode);
    @(negedge clk);
    byte_valid = 1'b1;
    byte_in = 8'hA5;
    #1;
    vectors++;
    if (byte_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL write_ready: byte_ready=%b during WRITE, required 0", byte_ready);
    end
    @(posedge clk);
  endtask

  task automatic read_all(input string tag);
    for (int a = 0; a < int'(DEPTH); a++) begin
      @(negedge clk);
      rd_addr = 3'(a);
      @(negedge clk);
      vectors++;
      if (rd_data !== mmem[a]) begin
        miscompares++;
        $display("FAIL %s_rd%0d: rd_data=%h, required %h", tag, a, rd_data, mmem[a]);
      end
    end
  endtask

  task automatic check_status(input string tag);
    vectors++;
    if (instr_count !== 4'(m_count) || program_ready !== m_pr || overflow !== m_ov) begin
      miscompares++;
      $display("FAIL %s_status: count=%0d pr=%b ov=%b, required count=%0d pr=%b ov=%b",
               tag, instr_count, program_ready, overflow, m_count, m_pr, m_ov);
    end
  endtask

  task automatic load_and_check(input logic [15:0] w[$], input int mode, input string tag,
                                input int exp_edges);
    int n;
    int cyc0;
    n = model_load(w);
    pulse_start();
    cyc0 = cyc;
    for (int i = 0; i < n; i++) send_word(w[i], mode);
    @(negedge clk);
    if (exp_edges > 0) begin
      vectors++;
      if (cyc - cyc0 != exp_edges || program_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL %s_latency: edges=%0d pr=%b, required edges=%0d pr=1", tag, cyc - cyc0, program_ready, exp_edges);
      end
    end
    byte_valid = 1'b0;
    check_status(tag);
    read_all(tag);
  endtask

  task automatic test_basic();
    logic [15:0] w[$];
    w = {16'h200F, 16'h4000, 16'h0000};
    load_and_check(w, 0, "basic", 9);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rd_addr = 3'd0;
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    vectors++;
    if (rd_data !== 16'h0 || instr_count !== 4'h0 || program_ready !== 1'b0 ||
        overflow !== 1'b0 || byte_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset: rd=%h cnt=%0d pr=%b ov=%b rdy=%b, required all 0",
               rd_data, instr_count, program_ready, overflow, byte_ready);
    end
    @(negedge clk);
    reset = 1'b1;
    model_clear_mem();
    check_status("reset");
    read_all("reset");
  endtask

  task automatic test_backpressure();
    logic [15:0] w[$];
    w = {16'h200F, 16'h4000, 16'h0000};
    load_and_check(w, 1, "bp", 0);
  endtask

  task automatic test_overflow();
    logic [15:0] w[$];
    for (int i = 0; i < 8; i++) w.push_back(16'h8000);
    load_and_check(w, 2, "ovf", 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      byte_valid = 1'b1;
      byte_in = 8'h11;
      #1;
      vectors++;
      if (byte_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL ovf_ninth: byte_ready=%b, required 0", byte_ready);
      end
    end
    @(negedge clk);
    byte_valid = 1'b0;
    check_status("ovf_hold");
  endtask

  task automatic test_abort();
    logic [15:0] w[$];
    pulse_start();
    send_byte(8'h20, 0);
    @(negedge clk);
    load_start = 1'b1;
    byte_valid = 1'b1;
    byte_in = 8'h0F;
    #1;
    vectors++;
    if (byte_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_ready: byte_ready=%b with load_start, required 0", byte_ready);
    end
    @(posedge clk);
    #1 load_start = 1'b0;
    byte_valid = 1'b0;
    @(negedge clk);
    m_count = 0; m_pr = 1'b0; m_ov = 1'b0;
    check_status("abort_hi");
    w = {16'h6000, 16'h0000};
    void'(model_load(w));
    send_word(16'h6000, 0);
    send_word(16'h0000, 0);
    @(negedge clk);
    byte_valid = 1'b0;
    check_status("abort");
    read_all("abort");
    // abort in the WRITE cycle: the word must not land in memory
    pulse_start();
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    @(negedge clk);
    load_start = 1'b1;
    @(posedge clk);
    #1 load_start = 1'b0;
    byte_valid = 1'b0;
    @(negedge clk);
    m_count = 0; m_pr = 1'b0; m_ov = 1'b0;
    check_status("abort_wr");
    read_all("abort_wr");
  endtask

  task automatic test_reset_midload();
    pulse_start();
    m_count = 0; m_pr = 1'b0; m_ov = 1'b0;
    send_word(16'h1234, 2);
    send_byte(8'h56, 2);
    #3 reset = 1'b0;
    #1;
    vectors++;
    if (instr_count !== 4'h0 || byte_ready !== 1'b0 || rd_data !== 16'h0) begin
      miscompares++;
      $display("FAIL midload_reset: cnt=%0d rdy=%b rd=%h, required 0 0 0", instr_count, byte_ready, rd_data);
    end
    @(negedge clk);
    reset = 1'b1;
    model_clear_mem();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      byte_valid = 1'b1;
      byte_in = 8'(k + 1);
      #1;
      vectors++;
      if (byte_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL midload_idle: byte_ready=%b without load_start, required 0", byte_ready);
      end
    end
    @(negedge clk);
    byte_valid = 1'b0;
    check_status("midload");
    read_all("midload");
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      logic [15:0] w[$];
      int len;
      len = int'($urandom_range(1, 10));
      for (int i = 0; i < len; i++) begin
        logic [15:0] v;
        v = 16'($urandom);
        if (v == 16'h0) v = 16'h0001;
        if ($urandom_range(0, 7) == 0) v = 16'h0000;
        w.push_back(v);
      end
      load_and_check(w, 2, "rand", 0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    model_clear_mem();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    check_status("por");
    test_basic();
    test_reset();
    test_backpressure();
    test_overflow();
    test_abort();
    test_reset_midload();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
